// File: rtl/set_job_dispatcher.sv
// Job feeder for the SET lattice-point counter: queues circle jobs in a FIFO,
// issues them over en/busy, and returns tagged results or watchdog aborts.
module set_job_dispatcher #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned AW      = 2,
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [23:0]   in_central,
    input  logic [11:0]   in_radius,
    input  logic [1:0]    in_mode,
    output logic          set_en,
    output logic [23:0]   set_central,
    output logic [11:0]   set_radius,
    output logic [1:0]    set_mode,
    input  logic          set_busy,
    input  logic          set_valid,
    input  logic [7:0]    set_candidate,
    output logic          res_valid,
    output logic [7:0]    res_tag,
    output logic [7:0]    res_candidate,
    output logic          res_err,
    output logic [AW:0]   fifo_count
);

    localparam int unsigned EW = 46;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_tag_ctr;

    state_e        r_state;
    logic [11:0]   r_wdog;
    logic [7:0]    r_job_tag;
    logic          r_set_en;
    logic [23:0]   r_set_central;
    logic [11:0]   r_set_radius;
    logic [1:0]    r_set_mode;
    logic          r_res_valid;
    logic [7:0]    r_res_tag;
    logic [7:0]    r_res_candidate;
    logic          r_res_err;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_head;

    assign w_full     = (r_count == (AW+1)'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push     = in_valid && !w_full;
    // Pop is the issue decision itself: the head is loaded into set_* on this edge.
    assign w_pop      = (r_state == StIdle) && !w_empty && !set_busy;
    assign w_head     = r_mem[r_rd_ptr];
    assign in_ready   = !w_full;
    assign fifo_count = r_count;

    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_mem[r_wr_ptr] <= {r_tag_ctr, in_mode, in_radius, in_central};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_tag_ctr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + AW'(1);
                r_tag_ctr <= r_tag_ctr + 8'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state         <= StIdle;
            r_wdog          <= '0;
            r_job_tag       <= '0;
            r_set_en        <= 1'b0;
            r_set_central   <= '0;
            r_set_radius    <= '0;
            r_set_mode      <= '0;
            r_res_valid     <= 1'b0;
            r_res_tag       <= '0;
            r_res_candidate <= '0;
            r_res_err       <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_pop) begin
                        r_job_tag     <= w_head[45:38];
                        r_set_mode    <= w_head[37:36];
                        r_set_radius  <= w_head[35:24];
                        r_set_central <= w_head[23:0];
                        r_set_en      <= 1'b1;
                        r_state       <= StIssue;
                    end
                end
                StIssue: begin
                    r_set_en <= 1'b0;
                    r_wdog   <= '0;
                    r_state  <= StWait;
                end
                StWait: begin
                    // A valid arriving on the timeout cycle still wins over the abort.
                    if (set_valid) begin
                        r_res_valid     <= 1'b1;
                        r_res_err       <= 1'b0;
                        r_res_tag       <= r_job_tag;
                        r_res_candidate <= set_candidate;
                        r_state         <= StIdle;
                    end else if (r_wdog == 12'(TIMEOUT)) begin
                        r_res_valid     <= 1'b1;
                        r_res_err       <= 1'b1;
                        r_res_tag       <= r_job_tag;
                        r_res_candidate <= '0;
                        r_state         <= StIdle;
                    end else begin
                        r_wdog <= r_wdog + 12'd1;
                    end
                end
                default: begin
                    r_set_en <= 1'b0;
                    r_state  <= StIdle;
                end
            endcase
        end
    end

    assign set_en        = r_set_en;
    assign set_central   = r_set_central;
    assign set_radius    = r_set_radius;
    assign set_mode      = r_set_mode;
    assign res_valid     = r_res_valid;
    assign res_tag       = r_res_tag;
    assign res_candidate = r_res_candidate;
    assign res_err       = r_res_err;

endmodule

// File: tb/tb_set_job_dispatcher.sv
// Randomized bench for set_job_dispatcher: a queue-based job model and a SET
// responder predict every issue strobe, held job field and tagged result.
module tb_set_job_dispatcher;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned AW      = 2;
    localparam int unsigned TIMEOUT = 4095;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_central;
    logic [11:0] in_radius;
    logic [1:0]  in_mode;
    logic        set_en;
    logic [23:0] set_central;
    logic [11:0] set_radius;
    logic [1:0]  set_mode;
    logic        set_busy;
    logic        set_valid;
    logic [7:0]  set_candidate;
    logic        res_valid;
    logic [7:0]  res_tag;
    logic [7:0]  res_candidate;
    logic        res_err;
    logic [AW:0] fifo_count;

    always #5 clk = ~clk;

    set_job_dispatcher #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_central   (in_central),
        .in_radius    (in_radius),
        .in_mode      (in_mode),
        .set_en       (set_en),
        .set_central  (set_central),
        .set_radius   (set_radius),
        .set_mode     (set_mode),
        .set_busy     (set_busy),
        .set_valid    (set_valid),
        .set_candidate(set_candidate),
        .res_valid    (res_valid),
        .res_tag      (res_tag),
        .res_candidate(res_candidate),
        .res_err      (res_err),
        .fifo_count   (fifo_count)
    );

    // lat < 0 means the SET responder never answers this job.
    typedef struct {
        logic [7:0]  tag;
        logic [23:0] c;
        logic [11:0] r;
        logic [1:0]  m;
        int          lat;
    } job_t;

    int total = 0;
    int bad   = 0;

    job_t       q[$];
    job_t       cur;
    bit         act;
    int         cyc = 0;
    int         res_cyc;
    int         valid_cyc;
    int         late_cyc = -1;
    int         n_done;
    int         next_lat = 1;
    bit         rand_busy = 1'b0;
    bit         last_push;
    logic [7:0] tag_ctr;
    logic [7:0] cand_val;
    logic [7:0] last_tag;
    logic [7:0] last_cand;
    logic       last_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one clock, update the model and compare every visible output.
    task automatic step();
        bit   push;
        bit   exp_en;
        bit   fire;
        job_t nj;
        if (rand_busy) set_busy = ($urandom_range(3) == 0);
        push   = in_valid && (q.size() < DEPTH);
        nj.tag = tag_ctr;
        nj.c   = in_central;
        nj.r   = in_radius;
        nj.m   = in_mode;
        nj.lat = next_lat;
        exp_en = !act && (q.size() > 0) && !set_busy;
        @(posedge clk);
        #1;
        cyc++;
        last_push = push;
        if (push) begin
            q.push_back(nj);
            tag_ctr++;
        end
        check("set_en", 32'(set_en), 32'(exp_en));
        if (exp_en) begin
            cur = q.pop_front();
            act = 1'b1;
            if (cur.lat >= 0) begin
                valid_cyc = cyc + cur.lat;
                res_cyc   = cyc + cur.lat + 1;
            end else begin
                valid_cyc = -1;
                res_cyc   = cyc + int'(TIMEOUT) + 2;
            end
        end
        if (act) begin
            check("set_central", 32'(set_central), 32'(cur.c));
            check("set_radius", 32'(set_radius), 32'(cur.r));
            check("set_mode", 32'(set_mode), 32'(cur.m));
        end
        fire = act && (cyc == res_cyc);
        check("res_valid", 32'(res_valid), 32'(fire));
        if (fire) begin
            last_tag  = cur.tag;
            last_err  = (cur.lat < 0);
            last_cand = (cur.lat < 0) ? 8'd0 : cand_val;
            if (cur.lat < 0) late_cyc = cyc + 1;
            act = 1'b0;
            n_done++;
        end
        check("res_tag", 32'(res_tag), 32'(last_tag));
        check("res_candidate", 32'(res_candidate), 32'(last_cand));
        check("res_err", 32'(res_err), 32'(last_err));
        check("fifo_count", 32'(fifo_count), 32'(q.size()));
        check("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        set_valid = 1'b0;
        if (act && cyc == valid_cyc) begin
            set_candidate = 8'($urandom);
            cand_val      = set_candidate;
            set_valid     = 1'b1;
        end else if (cyc == late_cyc) begin
            set_candidate = 8'($urandom);
            set_valid     = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        set_valid = 1'b0;
        set_busy  = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        q.delete();
        act       = 1'b0;
        tag_ctr   = 8'd0;
        last_tag  = 8'd0;
        last_cand = 8'd0;
        last_err  = 1'b0;
        late_cyc  = -1;
        n_done    = 0;
        check("rst_set_en", 32'(set_en), 32'd0);
        check("rst_set_central", 32'(set_central), 32'd0);
        check("rst_set_radius", 32'(set_radius), 32'd0);
        check("rst_set_mode", 32'(set_mode), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_tag", 32'(res_tag), 32'd0);
        check("rst_res_candidate", 32'(res_candidate), 32'd0);
        check("rst_res_err", 32'(res_err), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b1;
    endtask

    task automatic offer(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                         input int lat);
        int n = 0;
        in_valid   = 1'b1;
        in_central = c;
        in_radius  = r;
        in_mode    = m;
        next_lat   = lat;
        do begin
            step();
            n++;
        end while (!last_push && n < 10000);
        check("offer_accepted", 32'(last_push), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (n_done < n && k < budget) begin
            step();
            k++;
        end
        check("wait_done", 32'(n_done >= n), 32'd1);
    endtask

    initial begin
        rst           = 1'b0;
        in_valid      = 1'b0;
        in_central    = '0;
        in_radius     = '0;
        in_mode       = '0;
        set_busy      = 1'b0;
        set_valid     = 1'b0;
        set_candidate = '0;
        act           = 1'b0;
        do_reset();

        // Single job with a fixed 5-cycle SET response.
        offer(24'h434343, 12'h333, 2'b00, 5);
        wait_done(1, 50);
        check("t1_res_valid", 32'(res_valid), 32'd1);
        check("t1_tag", 32'(res_tag), 32'd0);

        // Fill the FIFO while SET is busy; a fifth offer stalls until the first pop.
        do_reset();
        set_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(24'($urandom), 12'($urandom), 2'(i), int'($urandom_range(1, 6)));
        end
        check("t2_full_ready", 32'(in_ready), 32'd0);
        check("t2_full_count", 32'(fifo_count), 32'd4);
        set_busy = 1'b0;
        offer(24'($urandom), 12'($urandom), 2'b11, 2);
        wait_done(5, 200);
        check("t2_last_tag", 32'(res_tag), 32'd4);

        // Busy hold-off for 20 cycles with a queued job.
        set_busy = 1'b1;
        offer(24'($urandom), 12'($urandom), 2'b01, 3);
        repeat (20) step();
        check("t3_held_count", 32'(fifo_count), 32'd1);
        set_busy = 1'b0;
        step();
        check("t3_en_after_busy", 32'(set_en), 32'd1);
        wait_done(6, 50);

        // Watchdog abort, late valid ignored, then a normal job.
        offer(24'($urandom), 12'($urandom), 2'b10, -1);
        wait_done(7, int'(TIMEOUT) + 50);
        check("t4_res_valid", 32'(res_valid), 32'd1);
        check("t4_err", 32'(res_err), 32'd1);
        check("t4_cand", 32'(res_candidate), 32'd0);
        offer(24'($urandom), 12'($urandom), 2'b00, 2);
        wait_done(8, 50);
        check("t4_next_err", 32'(res_err), 32'd0);
        check("t4_next_tag", 32'(res_tag), 32'd7);

        // Tag wrap over 257 randomized jobs with random busy.
        do_reset();
        rand_busy = 1'b1;
        for (int i = 0; i < 257; i++) begin
            offer(24'($urandom), 12'($urandom), 2'($urandom), int'($urandom_range(1, 4)));
            if ($urandom_range(3) == 0) step();
        end
        wait_done(257, 5000);
        rand_busy = 1'b0;
        set_busy  = 1'b0;
        check("t5_wrap_tag", 32'(res_tag), 32'd0);

        // Reset while a job waits and three more are queued.
        do_reset();
        offer(24'($urandom), 12'($urandom), 2'b01, -1);
        for (int i = 0; i < 3; i++) begin
            offer(24'($urandom), 12'($urandom), 2'b10, 2);
        end
        repeat (3) step();
        check("t6_queued", 32'(fifo_count), 32'd3);
        do_reset();
        offer(24'h123456, 12'habc, 2'b11, 2);
        wait_done(1, 50);
        check("t6_tag", 32'(res_tag), 32'd0);
        check("t6_err", 32'(res_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
